// File: rtl/dcache_pkg.sv
// Shared types and constants for the MEM-stage data cache.
// Ports: none (package). Address split: tag = addr[31:10], index = addr[9:5], word = addr[4:2].
// The controller state enum and the address-field helper live here so both cache files agree on them.
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int NUM_LINES  = 32;
    localparam int IDX_W      = 5;
    localparam int OFF_W      = 5;
    localparam int WORD_SEL_W = 3;
    localparam int WORDS      = 8;
    localparam int LINE_W     = 256;
    localparam int TAG_W      = ADDR_W - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        DONE      = 2'd3
    } state_t;

    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [IDX_W-1:0]      idx;
        logic [WORD_SEL_W-1:0] word;
    } addr_fields_t;

    // The byte offset addr[1:0] is dropped: only aligned word accesses exist.
    function automatic addr_fields_t split_addr(input logic [ADDR_W-1:0] addr);
        addr_fields_t f;
        f.tag  = addr[ADDR_W-1 -: TAG_W];
        f.idx  = addr[OFF_W +: IDX_W];
        f.word = addr[2 +: WORD_SEL_W];
        return f;
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/state array (valid, dirty, tag) plus line data array, one entry per cache line.
// Ports: idx_i selects the entry for both the async read (rd_*_o) and the single write port (we_i, wr_*_i).
// Reset clears only valid and dirty; tag and data contents are don't-care until a line is filled.
module dcache_sram
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              rd_valid_o,
    output logic              rd_dirty_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [LINE_W-1:0] rd_line_o,
    input  logic              we_i,
    input  logic              wr_valid_i,
    input  logic              wr_dirty_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [LINE_W-1:0] wr_line_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_dirty_o = dirty_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_line_o  = data_q[idx_i];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (we_i) begin
            valid_q[idx_i] <= wr_valid_i;
            dirty_q[idx_i] <= wr_dirty_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= wr_line_i;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
// Ports: cpu_* (EX/MEM request, 0-cycle load data, stall), mem_* (line-wide req/ack to data memory).
// A miss stalls the pipeline through optional victim write-back, refill and one DONE cycle.
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    addr_fields_t af;
    assign af = split_addr(cpu_addr_i);

    state_t      state_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;

    logic              rd_valid;
    logic              rd_dirty;
    logic [TAG_W-1:0]  rd_tag;
    logic [LINE_W-1:0] rd_line;

    logic              sram_we;
    logic              wr_dirty;
    logic [LINE_W-1:0] wr_line;

    logic              hit;
    logic              miss;
    logic [WORD_W-1:0] rd_word;
    logic [LINE_W-1:0] merged_line;

    dcache_sram u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .idx_i      (af.idx),
        .rd_valid_o (rd_valid),
        .rd_dirty_o (rd_dirty),
        .rd_tag_o   (rd_tag),
        .rd_line_o  (rd_line),
        .we_i       (sram_we),
        .wr_valid_i (1'b1),
        .wr_dirty_i (wr_dirty),
        .wr_tag_i   (af.tag),
        .wr_line_i  (wr_line)
    );

    assign hit  = cpu_req_i & rd_valid & (rd_tag == af.tag);
    assign miss = cpu_req_i & ~hit;

    // Word select for loads and word merge for stores share one decode.
    always_comb begin
        rd_word     = '0;
        merged_line = rd_line;
        for (int w = 0; w < WORDS; w++) begin
            if (af.word == w[WORD_SEL_W-1:0]) begin
                rd_word                    = rd_line[w*WORD_W +: WORD_W];
                merged_line[w*WORD_W +: WORD_W] = cpu_wdata_i;
            end
        end
    end

    // Two writers: a store hit in IDLE, and the refill completing in REFILL.
    always_comb begin
        sram_we  = 1'b0;
        wr_dirty = 1'b0;
        wr_line  = merged_line;
        if (state_q == IDLE && hit && cpu_we_i) begin
            sram_we  = 1'b1;
            wr_dirty = 1'b1;
        end else if (state_q == REFILL && mem_ack_i) begin
            sram_we  = 1'b1;
            wr_line  = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        mem_req_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q    <= WRITEBACK;
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= {rd_tag, af.idx, 5'b0};
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {af.tag, af.idx, 5'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    // Request stays up and turns straight into the refill read.
                    if (mem_ack_i) begin
                        state_q    <= REFILL;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {af.tag, af.idx, 5'b0};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_q   <= DONE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    // Index is frozen by the stalled pipeline, so the victim line is stable for the whole write-back.
    assign mem_wdata_o = rd_line;

    // Reset gating keeps stall low while the pipeline itself is being reset.
    assign cpu_stall_o = ~rst_i & ((state_q != IDLE) | miss);
    assign cpu_rdata_o = (state_q == IDLE && hit && !cpu_we_i) ? rd_word : '0;

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i;
    logic         mem_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [255:0] mem_lines [logic [31:0]];
    logic         txn_we    [$];
    logic [31:0]  txn_addr  [$];
    logic [255:0] txn_wdata [$];
    int           mem_lat   = 2;
    int           model_cnt = 0;
    int           stab_errs = 0;
    logic         hold_we;
    logic [31:0]  hold_addr;
    logic [255:0] hold_wdata;

    function automatic logic [255:0] get_line(input logic [31:0] a);
        logic [255:0] l;
        if (mem_lines.exists(a)) return mem_lines[a];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + i;
        return l;
    endfunction

    // Acks in the mem_lat-th cycle a request is seen; checks the request holds still until then.
    initial begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                model_cnt = 0;
            end
            if (rst_i) begin
                model_cnt = 0;
            end else if (mem_req_o) begin
                model_cnt++;
                if (model_cnt == 1) begin
                    hold_we    = mem_we_o;
                    hold_addr  = mem_addr_o;
                    hold_wdata = mem_wdata_o;
                end else if (mem_we_o !== hold_we || mem_addr_o !== hold_addr ||
                             (hold_we && mem_wdata_o !== hold_wdata)) begin
                    stab_errs++;
                end
                if (model_cnt >= mem_lat) begin
                    txn_we.push_back(hold_we);
                    txn_addr.push_back(hold_addr);
                    txn_wdata.push_back(hold_wdata);
                    if (hold_we) mem_lines[hold_addr] = hold_wdata;
                    else         mem_rdata_i = get_line(hold_addr);
                    mem_ack_i = 1'b1;
                end
            end else begin
                if (model_cnt > 0) stab_errs++;
                model_cnt = 0;
            end
        end
    end

    // ---------------- CPU side ----------------
    task automatic cpu_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output int stalls, output logic [31:0] rdata);
        @(posedge clk_i); #1;
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        stalls      = 0;
        forever begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            stalls++;
            if (stalls > 200) begin
                check("access_timeout", stalls, 200);
                break;
            end
        end
        rdata = cpu_rdata_o;
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    int          stalls;
    logic [31:0] rdata;
    int          base;
    int          wait_cnt;
    logic [255:0] l40;

    initial begin
        for (int i = 0; i < 8; i++) l40[i*32 +: 32] = i;
        mem_lines[32'h40] = l40;

        rst_i       = 1'b1;
        cpu_req_i   = 1'b1;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'h40;
        cpu_wdata_i = '0;
        #23;
        check("rst_stall",   cpu_stall_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_mem_we",  mem_we_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_rdata",   cpu_rdata_o, 0);
        cpu_req_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_noreq_stall", cpu_stall_o, 0);

        // 1: cold load miss, clean -> single refill
        base = txn_we.size();
        cpu_access(1'b0, 32'h40, '0, stalls, rdata);
        check("t1_stalls",    stalls, 4);
        check("t1_txn_count", txn_we.size() - base, 1);
        check("t1_txn_we",    txn_we[base], 0);
        check("t1_txn_addr",  txn_addr[base], 32'h40);
        check("t1_rdata",     rdata, 32'h0);
        check("t1_valid2",    u_dut.u_sram.valid_q[2], 1);

        // 2: load hit, same cycle data
        cpu_access(1'b0, 32'h44, '0, stalls, rdata);
        check("t2_stalls", stalls, 0);
        check("t2_rdata",  rdata, 32'h1);

        // 3: store hit then load hit
        base = txn_we.size();
        cpu_access(1'b1, 32'h48, 32'hDEAD_BEEF, stalls, rdata);
        check("t3_st_stalls", stalls, 0);
        cpu_access(1'b0, 32'h48, '0, stalls, rdata);
        check("t3_ld_stalls", stalls, 0);
        check("t3_rdata",     rdata, 32'hDEAD_BEEF);
        check("t3_dirty2",    u_dut.u_sram.dirty_q[2], 1);
        check("t3_no_txn",    txn_we.size() - base, 0);

        // 4: conflict miss on dirty line -> write-back then refill
        base = txn_we.size();
        cpu_access(1'b0, 32'h440, '0, stalls, rdata);
        check("t4_stalls",    stalls, 6);
        check("t4_txn_count", txn_we.size() - base, 2);
        check("t4_wb_we",     txn_we[base], 1);
        check("t4_wb_addr",   txn_addr[base], 32'h40);
        check("t4_wb_word2",  txn_wdata[base][95:64], 32'hDEAD_BEEF);
        check("t4_wb_word1",  txn_wdata[base][63:32], 32'h1);
        check("t4_rf_we",     txn_we[base+1], 0);
        check("t4_rf_addr",   txn_addr[base+1], 32'h440);
        check("t4_rdata",     rdata, 32'h440);
        check("t4_dirty2",    u_dut.u_sram.dirty_q[2], 0);
        check("t4_mem_line",  mem_lines[32'h40][95:64], 32'hDEAD_BEEF);

        // 5: slow memory, clean victim -> stall = 1 + 10 + 1
        mem_lat = 10;
        base = txn_we.size();
        cpu_access(1'b0, 32'h84C, '0, stalls, rdata);
        check("t5_stalls",    stalls, 12);
        check("t5_stable",    stab_errs, 0);
        check("t5_txn_count", txn_we.size() - base, 1);
        check("t5_rf_addr",   txn_addr[base], 32'h840);
        check("t5_rdata",     rdata, 32'h843);

        // 6: reset in the middle of a write-back
        mem_lat = 2;
        cpu_access(1'b1, 32'h840, 32'h1234_5678, stalls, rdata);
        check("t6_store_stalls", stalls, 0);
        mem_lat = 20;
        base = txn_we.size();
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'hC40;
        wait_cnt   = 0;
        do begin
            @(negedge clk_i);
            wait_cnt++;
        end while (!(mem_req_o && mem_we_o) && wait_cnt < 50);
        check("t6_wb_started", mem_req_o & mem_we_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_rst_mem_req", mem_req_o, 0);
        check("t6_rst_stall",   cpu_stall_o, 0);
        @(negedge clk_i);
        cpu_req_i = 1'b0;
        rst_i     = 1'b0;
        mem_lat   = 2;
        check("t6_no_wb_done", txn_we.size() - base, 0);
        cpu_access(1'b0, 32'h840, '0, stalls, rdata);
        check("t6_miss_stalls", stalls, 4);
        check("t6_txn_count",   txn_we.size() - base, 1);
        check("t6_rf_we",       txn_we[base], 0);
        check("t6_rf_addr",     txn_addr[base], 32'h840);
        check("t6_rdata",       rdata, 32'h840);
        check("t6_stable",      stab_errs, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
